vpu_dst_port: RTL and testbench
===============================

# vpu_dst_port

Destination-side writer for VPU operation units such as the FP average datapath: it takes the one-cycle `done`/`result` pulses an op unit emits and turns them into sequential writes to one SRAM write port. The op unit pipeline cannot be stalled, so results land in a small FIFO before being written. The FIFO drains under `sram_wr_ready_i` backpressure, starting at a programmed base address and stopping after a programmed count. It sits between the op units and SRAM and reports completion to the VPU controller.

## Interface
Parameters:
- `OPERAND_WIDTH`, default 16: result/SRAM data width (bf16).
- `ADDR_WIDTH`, default 10: SRAM word address width.
- `LEN_WIDTH`, default 11: transfer-length counter width.
- `FIFO_DEPTH`, default 4: result buffer entries; must be a power of 2 and at least 2.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_start_i` in 1: one-cycle pulse that launches a transfer; ignored while `busy_o`=1.
- `cfg_base_addr_i` in ADDR_WIDTH: first write address; sampled with `cfg_start_i`.
- `cfg_len_i` in LEN_WIDTH: number of results to write; sampled with `cfg_start_i`.
- `result_i` in OPERAND_WIDTH: op-unit result.
- `done_i` in 1: `result_i` valid this cycle; there is no backpressure to the op unit.
- `sram_wr_en_o` out 1: write request.
- `sram_wr_addr_o` out ADDR_WIDTH: write address.
- `sram_wr_data_o` out OPERAND_WIDTH: write data.
- `sram_wr_ready_i` in 1: the write is accepted when `sram_wr_en_o` & `sram_wr_ready_i`.
- `busy_o` out 1: transfer in progress.
- `complete_o` out 1: one-cycle pulse after the last write is accepted.
- `err_o` out 1: sticky error; set on overflow or a stray `done_i`, cleared by `cfg_start_i` or `rst`.

## Operation
- States: IDLE, RUN, CPL.
- IDLE → RUN on `cfg_start_i`. On that edge:
  - latch the base address into `wr_addr`;
  - latch `cfg_len_i` into `remaining`;
  - clear `err_o`.
- RUN, push:
  - each `done_i` pushes `result_i` into the FIFO;
  - pushes stop once pushed count = len; any extra `done_i` is dropped and sets `err_o`.
- RUN, pop:
  - `sram_wr_en_o` = RUN & FIFO not empty;
  - data comes from the FIFO head; address is `wr_addr`;
  - on acceptance: pop, `wr_addr` += 1 (wraps modulo 2^ADDR_WIDTH), `remaining` -= 1.
- RUN → CPL when the accepting write takes `remaining` from 1 to 0. CPL asserts `complete_o` for one cycle, then → IDLE.
- `cfg_len_i`=0: RUN lasts one cycle with no writes, then CPL.
- Push and pop in the same cycle are both legal:
  - when the FIFO is full, the pop frees the slot and the push succeeds;
  - when the FIFO is empty, the push is written and the pop does not occur, because `sram_wr_en_o` was low.
- FIFO full and `done_i` without a same-cycle pop: the result is dropped, `err_o` is set, and the count is not advanced.
- `done_i` in IDLE or CPL: dropped, `err_o` is set.
- `cfg_start_i` while busy: ignored; no error.
- Reset mid-transfer: FIFO emptied, state → IDLE, partial writes are not retried.

## Timing
- Reset values:
  - `sram_wr_en_o`=0, `sram_wr_addr_o`=0, `sram_wr_data_o`=0;
  - `busy_o`=0, `complete_o`=0, `err_o`=0.
- `busy_o`=1 in RUN and CPL; it rises the cycle after `cfg_start_i`.
- Latency: `done_i` at cycle t → `sram_wr_en_o`=1 at t+1, with ready held high.
- Throughput: one write per cycle sustained with ready=1.
- `sram_wr_addr_o`/`sram_wr_data_o` hold stable while `sram_wr_en_o`=1 and `sram_wr_ready_i`=0.
- `complete_o` appears the cycle after the final accepted write. A new `cfg_start_i` is accepted the cycle after `complete_o`.

## Structure
- `VPU_PKG` holds:
  - `OPERAND_WIDTH`, SRAM address width;
  - the state enum `dst_state_t` {IDLE, RUN, CPL}.
- Sub-module `vpu_dst_fifo`: synchronous FIFO with pointers one bit wider than the index for full/empty detection.
  - Interface: `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - Same-cycle push+pop when full is legal.
- The top level holds the FSM, address/length counters and error logic.

## Test plan
- Base=0x010, len=3, `done_i` on 3 consecutive cycles, ready=1 → writes at 0x010/0x011/0x012 with matching data at t+1..t+3; `complete_o` one cycle after; `err_o`=0.
- Len=6, ready=0 for 8 cycles while 4 `done_i` arrive → FIFO full, no error. A 5th `done_i` arriving with ready still 0 → dropped, `err_o`=1, and the transfer never completes (5 pushes max, 4 buffered).
- Full FIFO, `done_i` and accepted pop in the same cycle → no drop, occupancy stays 4, `err_o`=0.
- Base=0x3FE, len=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Len=0 → no `sram_wr_en_o`, `complete_o` 2 cycles after `cfg_start_i`. Stray `done_i` in IDLE → `err_o`=1, cleared by the next `cfg_start_i`.
- `rst` asserted after 2 of 5 writes → all outputs 0 the next cycle. A new transfer then starts cleanly at its own base address.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared VPU constants and the destination-port state encoding.
package vpu_pkg;

  localparam int VPU_OPERAND_WIDTH = 16;  // bf16 results
  localparam int VPU_ADDR_WIDTH    = 10;  // SRAM word address

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CPL  = 2'd2
  } dst_state_t;

endpackage

// File: rtl/vpu_dst_fifo.sv
// Small synchronous result FIFO; pointers carry an extra wrap bit so full and
// empty are told apart without a separate occupancy counter.
module vpu_dst_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vpu_dst_port.sv
// Destination writer: buffers non-stallable op-unit results and drains them as
// sequential SRAM writes from a programmed base for a programmed count.
module vpu_dst_port
  import vpu_pkg::*;
#(
  parameter int OPERAND_WIDTH = VPU_OPERAND_WIDTH,
  parameter int ADDR_WIDTH    = VPU_ADDR_WIDTH,
  parameter int LEN_WIDTH     = 11,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start_i,
  input  logic [ADDR_WIDTH-1:0]    cfg_base_addr_i,
  input  logic [LEN_WIDTH-1:0]     cfg_len_i,
  input  logic [OPERAND_WIDTH-1:0] result_i,
  input  logic                     done_i,
  output logic                     sram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]    sram_wr_addr_o,
  output logic [OPERAND_WIDTH-1:0] sram_wr_data_o,
  input  logic                     sram_wr_ready_i,
  output logic                     busy_o,
  output logic                     complete_o,
  output logic                     err_o
);

  dst_state_t               state_q;
  logic [ADDR_WIDTH-1:0]    wr_addr_q;
  logic [LEN_WIDTH-1:0]     remaining_q, len_q, pushed_q;
  logic                     err_q;

  logic                     fifo_full, fifo_empty;
  logic [OPERAND_WIDTH-1:0] fifo_dout;
  logic                     run, start_ok, wr_en, wr_accept, push_ok;

  assign run       = (state_q == RUN);
  assign start_ok  = cfg_start_i && (state_q == IDLE);
  assign wr_en     = run && !fifo_empty;
  assign wr_accept = wr_en && sram_wr_ready_i;
  assign push_ok   = done_i && run && (pushed_q != len_q) && (!fifo_full || wr_accept);

  vpu_dst_fifo #(
    .WIDTH (OPERAND_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (wr_accept),
    .din   (result_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      pushed_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cfg_start_i) begin
          state_q     <= RUN;
          wr_addr_q   <= cfg_base_addr_i;
          remaining_q <= cfg_len_i;
          len_q       <= cfg_len_i;
          pushed_q    <= '0;
        end
        RUN: begin
          if (push_ok) pushed_q <= pushed_q + LEN_WIDTH'(1);
          if (wr_accept) begin
            wr_addr_q   <= wr_addr_q + ADDR_WIDTH'(1);
            remaining_q <= remaining_q - LEN_WIDTH'(1);
          end
          // remaining is only 0 here for a zero-length transfer.
          if (remaining_q == '0 || (wr_accept && remaining_q == LEN_WIDTH'(1)))
            state_q <= CPL;
        end
        CPL:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (start_ok)                err_q <= 1'b0;
      else if (done_i && !push_ok) err_q <= 1'b1;
    end
  end

  assign sram_wr_en_o   = wr_en;
  assign sram_wr_addr_o = wr_addr_q;
  // Head entry may be uninitialised storage, so data is forced to 0 when not writing.
  assign sram_wr_data_o = wr_en ? fifo_dout : '0;
  assign busy_o         = (state_q != IDLE);
  assign complete_o     = (state_q == CPL);
  assign err_o          = err_q;

endmodule

// File: tb/tb_vpu_dst_port.sv
// Scoreboard bench for vpu_dst_port: expected writes are queued as results are
// issued and a negedge monitor compares every accepted SRAM write.
module tb_vpu_dst_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start_i;
  logic [9:0]  cfg_base_addr_i;
  logic [10:0] cfg_len_i;
  logic [15:0] result_i;
  logic        done_i;
  logic        sram_wr_en_o;
  logic [9:0]  sram_wr_addr_o;
  logic [15:0] sram_wr_data_o;
  logic        sram_wr_ready_i;
  logic        busy_o, complete_o, err_o;

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  always #5 clk = ~clk;

  vpu_dst_port dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start_i     (cfg_start_i),
    .cfg_base_addr_i (cfg_base_addr_i),
    .cfg_len_i       (cfg_len_i),
    .result_i        (result_i),
    .done_i          (done_i),
    .sram_wr_en_o    (sram_wr_en_o),
    .sram_wr_addr_o  (sram_wr_addr_o),
    .sram_wr_data_o  (sram_wr_data_o),
    .sram_wr_ready_i (sram_wr_ready_i),
    .busy_o          (busy_o),
    .complete_o      (complete_o),
    .err_o           (err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one result for the next cycle and queue the write it must produce.
  task automatic issue(input logic [9:0] addr, input logic [15:0] data, input bit expect_wr);
    done_i   = 1'b1;
    result_i = data;
    if (expect_wr) exp_q.push_back('{addr: addr, data: data});
  endtask

  task automatic start(input logic [9:0] base, input logic [10:0] len);
    cfg_start_i     = 1'b1;
    cfg_base_addr_i = base;
    cfg_len_i       = len;
    tick();
    cfg_start_i     = 1'b0;
  endtask

  task automatic wait_complete(input string name, input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (complete_o) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_complete"}, {31'd0, seen}, 32'd1);
  endtask

  // Monitor: every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && sram_wr_en_o && sram_wr_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {22'd0, sram_wr_addr_o}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {22'd0, sram_wr_addr_o}, {22'd0, e.addr});
        check("wr_data", {16'd0, sram_wr_data_o}, {16'd0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cpl_seen;
    rst = 1'b1; cfg_start_i = 1'b0; cfg_base_addr_i = '0; cfg_len_i = '0;
    result_i = '0; done_i = 1'b0; sram_wr_ready_i = 1'b1;
    repeat (3) tick();
    check("rst_wr_en",    {31'd0, sram_wr_en_o}, 32'd0);
    check("rst_wr_addr",  {22'd0, sram_wr_addr_o}, 32'd0);
    check("rst_wr_data",  {16'd0, sram_wr_data_o}, 32'd0);
    check("rst_busy",     {31'd0, busy_o}, 32'd0);
    check("rst_complete", {31'd0, complete_o}, 32'd0);
    check("rst_err",      {31'd0, err_o}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic: base 0x010, len 3, back-to-back results.
    start(10'h010, 11'd3);
    check("t1_busy", {31'd0, busy_o}, 32'd1);
    issue(10'h010, 16'h3F80, 1'b1); tick();
    check("t1_latency_en", {31'd0, sram_wr_en_o}, 32'd1);
    issue(10'h011, 16'h4000, 1'b1); tick();
    issue(10'h012, 16'h4040, 1'b1); tick();
    done_i = 1'b0;
    tick();
    check("t1_complete", {31'd0, complete_o}, 32'd1);
    check("t1_err", {31'd0, err_o}, 32'd0);
    check("t1_en_in_cpl", {31'd0, sram_wr_en_o}, 32'd0);
    tick();
    check("t1_complete_pulse", {31'd0, complete_o}, 32'd0);
    check("t1_idle", {31'd0, busy_o}, 32'd0);

    // Backpressure overflow: len 6, four results fill the FIFO, a fifth is dropped.
    sram_wr_ready_i = 1'b0;
    start(10'h100, 11'd6);
    for (int i = 0; i < 4; i++) begin
      issue(10'h100 + 10'(i), 16'hB000 + 16'(i), 1'b1);
      tick();
    end
    check("t2_full_no_err", {31'd0, err_o}, 32'd0);
    check("t2_hold_addr", {22'd0, sram_wr_addr_o}, 32'h100);
    check("t2_hold_data", {16'd0, sram_wr_data_o}, 32'hB000);
    issue(10'h104, 16'hB004, 1'b0); tick();
    done_i = 1'b0;
    check("t2_drop_err", {31'd0, err_o}, 32'd1);
    repeat (2) tick();
    sram_wr_ready_i = 1'b1;
    cpl_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (complete_o) cpl_seen = 1'b1;
    end
    check("t2_never_complete", {31'd0, cpl_seen}, 32'd0);
    check("t2_still_busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t2_rst_idle", {31'd0, busy_o}, 32'd0);

    // Full FIFO with a same-cycle push and accepted pop: nothing is lost.
    sram_wr_ready_i = 1'b0;
    start(10'h200, 11'd6);
    for (int i = 0; i < 4; i++) begin
      issue(10'h200 + 10'(i), 16'hC000 + 16'(i), 1'b1);
      tick();
    end
    sram_wr_ready_i = 1'b1;
    issue(10'h204, 16'hC004, 1'b1); tick();
    sram_wr_ready_i = 1'b0; done_i = 1'b0;
    check("t3_no_err", {31'd0, err_o}, 32'd0);
    check("t3_head_addr", {22'd0, sram_wr_addr_o}, 32'h201);
    check("t3_head_data", {16'd0, sram_wr_data_o}, 32'hC001);
    sram_wr_ready_i = 1'b1;
    issue(10'h205, 16'hC005, 1'b1); tick();
    done_i = 1'b0;
    wait_complete("t3", 20);
    check("t3_err_end", {31'd0, err_o}, 32'd0);
    tick();

    // Address wrap at the top of the SRAM.
    start(10'h3FE, 11'd4);
    issue(10'h3FE, 16'hD000, 1'b1); tick();
    issue(10'h3FF, 16'hD001, 1'b1); tick();
    issue(10'h000, 16'hD002, 1'b1); tick();
    issue(10'h001, 16'hD003, 1'b1); tick();
    done_i = 1'b0;
    wait_complete("t4", 10);
    tick();

    // Zero-length transfer completes two cycles after start, with no writes.
    start(10'h055, 11'd0);
    check("t5_len0_run_en", {31'd0, sram_wr_en_o}, 32'd0);
    check("t5_len0_run_cpl", {31'd0, complete_o}, 32'd0);
    tick();
    check("t5_len0_complete", {31'd0, complete_o}, 32'd1);
    tick();
    check("t5_len0_idle", {31'd0, busy_o}, 32'd0);

    // Stray result in IDLE sets err; the next start clears it; start while busy is ignored.
    issue(10'h000, 16'hEEEE, 1'b0); tick();
    done_i = 1'b0;
    check("t5_stray_err", {31'd0, err_o}, 32'd1);
    start(10'h060, 11'd1);
    check("t5_err_cleared", {31'd0, err_o}, 32'd0);
    cfg_start_i = 1'b1; cfg_base_addr_i = 10'h3AA; cfg_len_i = 11'd9;
    issue(10'h060, 16'h1234, 1'b1); tick();
    cfg_start_i = 1'b0; done_i = 1'b0;
    check("t5_busy_start_no_err", {31'd0, err_o}, 32'd0);
    wait_complete("t5", 10);
    tick();

    // Reset after two of five writes, then a clean transfer at a new base.
    start(10'h080, 11'd5);
    issue(10'h080, 16'hF000, 1'b1); tick();
    issue(10'h081, 16'hF001, 1'b1); tick();
    issue(10'h082, 16'hF002, 1'b0); tick();
    done_i = 1'b0; sram_wr_ready_i = 1'b0; rst = 1'b1;
    tick();
    check("t6_rst_en",   {31'd0, sram_wr_en_o}, 32'd0);
    check("t6_rst_addr", {22'd0, sram_wr_addr_o}, 32'd0);
    check("t6_rst_data", {16'd0, sram_wr_data_o}, 32'd0);
    check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    check("t6_rst_err",  {31'd0, err_o}, 32'd0);
    rst = 1'b0; sram_wr_ready_i = 1'b1;
    tick();
    start(10'h0C0, 11'd2);
    issue(10'h0C0, 16'hA5A5, 1'b1); tick();
    check("t6_new_base", {22'd0, sram_wr_addr_o}, 32'h0C0);
    issue(10'h0C1, 16'h5A5A, 1'b1); tick();
    done_i = 1'b0;
    wait_complete("t6", 10);
    check("t6_err", {31'd0, err_o}, 32'd0);
    tick();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
